// File: rtl/vga_timing_counter.sv
// -----------------------------------------------------------------------------
// vga_timing_counter
//
// Free-running horizontal/vertical pixel counters for 640x480 @ 60 Hz VGA
// timing. The system clock is divided down to a pixel-rate strobe
// (pixel_tick) and the counters advance once per pixel. The block also
// produces single-cycle line, frame and vertical-blank event pulses.
//
// Optional build feature:
//   VGA_FRAME_COUNT_EN - when defined, adds a 16-bit frame_count output that
//                        increments on every frame wrap (same edge that sets
//                        frame_start). Absent from the default build.
//
// Parameters:
//   CLK_DIV  - system clocks per pixel (1..16)
//   H_TOTAL  - pixels per line, including blanking
//   V_TOTAL  - lines per frame, including blanking
//   V_ACTIVE - first non-display line (vblank_start fires on entering it)
//
// Ports:
//   clk          in   system clock, all state on its rising edge
//   rst_n        in   synchronous reset, active low (overrides en)
//   en           in   count enable; low freezes divider and counters
//   pixel_tick   out  one-clk strobe per pixel period; counters advance on
//                     the rising edge that ends this cycle
//   h_count[9:0] out  horizontal pixel index 0..H_TOTAL-1 (registered)
//   v_count[9:0] out  vertical line index 0..V_TOTAL-1 (registered)
//   line_end     out  pixel_tick qualified by h_count==H_TOTAL-1
//   frame_start  out  registered one-clk pulse on the first clk of h=0,v=0
//                     after a frame wrap (never after reset release)
//   vblank_start out  registered one-clk pulse on the first clk of
//                     v=V_ACTIVE, h=0
//   frame_count  out  (VGA_FRAME_COUNT_EN only) frames completed, wraps
//
// Strobe semantics: pixel_tick, line_end, frame_start and vblank_start are
// qualifier strobes with no backpressure. A consumer acts in the single clk
// the strobe is high; there is no ready, and nothing is held for a late
// consumer.
// -----------------------------------------------------------------------------
module vga_timing_counter #(
  parameter int CLK_DIV  = 4,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        pixel_tick,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        line_end,
  output logic        frame_start,
  output logic        vblank_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  // A 1-bit divider is kept even for CLK_DIV=1; it simply stays at 0.
  localparam int              DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]      H_MAX       = 10'(H_TOTAL - 1);
  localparam logic [9:0]      V_MAX       = 10'(V_TOTAL - 1);
  // Last display line: when it ends, the next line is the first blank line.
  localparam logic [9:0]      V_LAST_DISP = 10'(V_ACTIVE - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             h_last;
  logic             v_last;
  logic             v_last_disp;

  // All decodes come straight from registers, so downstream timing sees a
  // single compare level.
  assign h_last      = (h_count == H_MAX);
  assign v_last      = (v_count == V_MAX);
  assign v_last_disp = (v_count == V_LAST_DISP);

  assign pixel_tick  = en & (div_cnt == DIV_MAX);
  assign line_end    = pixel_tick & h_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      h_count      <= '0;
      v_count      <= '0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
      frame_count  <= '0;
`endif
    end else begin
      // Event pulses default low so each lasts exactly one clk, even though
      // the counter values they mark persist for CLK_DIV clks.
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;

      if (en) begin
        if (div_cnt == DIV_MAX) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      // pixel_tick already includes en, so a frozen block never advances.
      if (pixel_tick) begin
        if (h_last) begin
          h_count <= '0;
          if (v_last) begin
            v_count     <= '0;
            frame_start <= 1'b1;
`ifdef VGA_FRAME_COUNT_EN
            frame_count <= frame_count + 16'd1;
`endif
          end else begin
            v_count <= v_count + 10'd1;
          end
          if (v_last_disp) begin
            vblank_start <= 1'b1;
          end
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_counter.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_counter
//
// Two instances: dut uses CLK_DIV=4 with a short 6-line frame (V_ACTIVE=4) so
// a full frame wrap, vblank, enable freeze and mid-frame reset fit in a short
// run while the line length stays the real 800 pixels; dut1 uses CLK_DIV=1
// with default geometry for the undivided case. Expected ticks and events are
// pushed into queues with the clk number at which they must appear; negedge
// monitors pop and compare whenever the DUT presents a strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_counter;

  localparam int H_T   = 800;
  localparam int V_T   = 6;
  localparam int V_ACT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n, en, rst1_n, en1;
  logic       pixel_tick, line_end, frame_start, vblank_start;
  logic [9:0] h_count, v_count;
  logic       pixel_tick1, line_end1, frame_start1, vblank_start1;
  logic [9:0] h_count1, v_count1;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count, frame_count1;
`endif

  vga_timing_counter #(
    .CLK_DIV(4), .H_TOTAL(H_T), .V_TOTAL(V_T), .V_ACTIVE(V_ACT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pixel_tick(pixel_tick), .h_count(h_count), .v_count(v_count),
    .line_end(line_end), .frame_start(frame_start), .vblank_start(vblank_start)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  vga_timing_counter #(
    .CLK_DIV(1), .H_TOTAL(800), .V_TOTAL(525), .V_ACTIVE(480)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1),
    .pixel_tick(pixel_tick1), .h_count(h_count1), .v_count(v_count1),
    .line_end(line_end1), .frame_start(frame_start1), .vblank_start(vblank_start1)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count(frame_count1)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // tick entry: {clk[31:0], line_end, v[9:0], h[9:0]}
  logic [52:0] exp_q[$];
  logic [52:0] exp1_q[$];
  // event entry: {clk[31:0], kind{vblank,frame}, frame_count[15:0], v, h}
  logic [69:0] ev_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (clk %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: strobe at clk %0d (h=%0d v=%0d), none expected", name, cyc, h_count, v_count);
  endtask

  logic [52:0] mt;
  logic [69:0] me;
  logic [52:0] mt1;

  // Monitor for dut
  always @(negedge clk) begin
    check("line_end_without_tick", {63'd0, line_end & ~pixel_tick}, 64'd0);
    if (pixel_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        unexpected("tick");
      end else begin
        mt = exp_q.pop_front();
        check("tick_clk", 64'(cyc), 64'(mt[52:21]));
        check("tick_line_end", 64'(line_end), 64'(mt[20]));
        check("tick_v", 64'(v_count), 64'(mt[19:10]));
        check("tick_h", 64'(h_count), 64'(mt[9:0]));
      end
    end
    if (frame_start === 1'b1 || vblank_start === 1'b1) begin
      if (ev_q.size() == 0) begin
        unexpected("event");
      end else begin
        me = ev_q.pop_front();
        check("event_clk", 64'(cyc), 64'(me[69:38]));
        check("event_kind", 64'({vblank_start, frame_start}), 64'(me[37:36]));
        check("event_v", 64'(v_count), 64'(me[19:10]));
        check("event_h", 64'(h_count), 64'(me[9:0]));
`ifdef VGA_FRAME_COUNT_EN
        check("event_frame_count", 64'(frame_count), 64'(me[35:20]));
`endif
      end
    end
  end

  // Monitor for dut1
  always @(negedge clk) begin
    check("dut1_no_events", 64'({frame_start1, vblank_start1}), 64'd0);
    if (pixel_tick1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        unexpected("dut1_tick");
      end else begin
        mt1 = exp1_q.pop_front();
        check("dut1_tick_clk", 64'(cyc), 64'(mt1[52:21]));
        check("dut1_line_end", 64'(line_end1), 64'(mt1[20]));
        check("dut1_v", 64'(v_count1), 64'(mt1[19:10]));
        check("dut1_h", 64'(h_count1), 64'(mt1[9:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) step();
  endtask

  // ---------------- stimulus ----------------
  int unsigned r0, r1, r2;
  logic [9:0]  hh, vv;
  int unsigned st;
  int          idx;

  initial begin
    rst_n = 1'b0; en = 1'b1; rst1_n = 1'b0; en1 = 1'b0;
    repeat (3) step();

    // ---- CLK_DIV=1: tick every clk, 800-clk line ----
    check("dut1_reset_tick", 64'(pixel_tick1), 64'd0);
    check("dut1_reset_h", 64'(h_count1), 64'd0);
    check("dut1_reset_v", 64'(v_count1), 64'd0);
    r1 = cyc;
    for (int n = 1; n <= 805; n++) begin
      idx = n - 1;
      hh  = 10'(idx % 800);
      vv  = 10'(idx / 800);
      st  = r1 + n - 1;
      exp1_q.push_back({st, (hh == 10'd799), vv, hh});
    end
    rst1_n = 1'b1; en1 = 1'b1;
    wait_cyc(r1 + 805);
    en1 = 1'b0;
    wait_cyc(r1 + 810);
    check("dut1_hold_h", 64'(h_count1), 64'd5);
    check("dut1_hold_v", 64'(v_count1), 64'd1);
    check("dut1_queue_drained", 64'(exp1_q.size()), 64'd0);

    // ---- CLK_DIV=4: reset state, start-up, vblank, frame wrap ----
    check("reset_h", 64'(h_count), 64'd0);
    check("reset_v", 64'(v_count), 64'd0);
    check("reset_pulses", 64'({pixel_tick, line_end, frame_start, vblank_start}), 64'd0);
`ifdef VGA_FRAME_COUNT_EN
    check("reset_frame_count", 64'(frame_count), 64'd0);
`endif
    r0 = cyc;
    // Ticks after the freeze (n > 4900) arrive 10 clks later.
    for (int n = 1; n <= 6000; n++) begin
      idx = n - 1;
      hh  = 10'(idx % H_T);
      vv  = 10'((idx / H_T) % V_T);
      st  = r0 + 4 * n - 1 + ((n > 4900) ? 10 : 0);
      exp_q.push_back({st, (hh == 10'd799), vv, hh});
    end
    ev_q.push_back({r0 + 32'd12800, 2'b10, 16'd0, 10'd4, 10'd0});
    ev_q.push_back({r0 + 32'd19200, 2'b01, 16'd1, 10'd0, 10'd0});
    rst_n = 1'b1;

    // ---- enable freeze at h=100, div_cnt=2 ----
    wait_cyc(r0 + 19602);
    check("pre_freeze_h", 64'(h_count), 64'd100);
    check("pre_freeze_v", 64'(v_count), 64'd0);
    en = 1'b0;
    wait_cyc(r0 + 19607);
    check("freeze_h", 64'(h_count), 64'd100);
    check("freeze_strobes", 64'({pixel_tick, line_end}), 64'd0);
    wait_cyc(r0 + 19612);
    en = 1'b1;

    // ---- reset mid-frame at h=400 ----
    wait_cyc(r0 + 24011);
    check("pre_reset_h", 64'(h_count), 64'd400);
    check("pre_reset_v", 64'(v_count), 64'd1);
    check("queue_drained_pre_reset", 64'(exp_q.size() + ev_q.size()), 64'd0);
`ifdef VGA_FRAME_COUNT_EN
    check("pre_reset_frame_count", 64'(frame_count), 64'd1);
`endif
    rst_n = 1'b0;
    step();
    check("midreset_h", 64'(h_count), 64'd0);
    check("midreset_v", 64'(v_count), 64'd0);
    check("midreset_pulses", 64'({pixel_tick, line_end, frame_start, vblank_start}), 64'd0);
`ifdef VGA_FRAME_COUNT_EN
    check("midreset_frame_count", 64'(frame_count), 64'd0);
`endif
    r2 = cyc;
    for (int n = 1; n <= 3; n++) begin
      hh = 10'(n - 1);
      st = r2 + 4 * n - 1;
      exp_q.push_back({st, 1'b0, 10'd0, hh});
    end
    rst_n = 1'b1;
    wait_cyc(r2 + 12);
    en = 1'b0;
    wait_cyc(r2 + 20);
    check("post_reset_h", 64'(h_count), 64'd3);
    check("post_reset_v", 64'(v_count), 64'd0);
    check("final_queue_drained", 64'(exp_q.size() + ev_q.size() + exp1_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at clk %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
